axi_burst_responder: RTL

Executes the memory-side end of the hline/zbuff request protocol. It accepts `rd_req` / `wr_req` plus `addr` from the pcore FSM and runs each request as one AXI4 burst on the master port. Read beats are pushed into the pcore input FIFOs, and write beats are popped from the output FIFO. Completion of each request is reported with a single-cycle `axi_done` pulse. It sits between the pcore FSM/FIFOs and the PLB/AXI interconnect.

---
 rtl/axi_burst_responder_if.sv | 54 +++++
 rtl/axi_burst_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/axi_burst_responder_if.sv
// AXI4 master-port bundle for the burst responder (AR, R, AW, W, B channels).
interface axi_burst_responder_if;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        m_arvalid;
    logic        m_arready;

    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic        m_rvalid;
    logic        m_rready;

    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic        m_awvalid;
    logic        m_awready;

    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;

    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    modport master (
        output m_araddr, m_arlen, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output m_awaddr, m_awlen, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        input  m_araddr, m_arlen, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  m_awaddr, m_awlen, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bresp, m_bvalid,
        input  m_bready
    );
endinterface

// File: rtl/axi_burst_responder.sv
// Memory-side end of the hline/zbuff request protocol: each rd_req/wr_req runs as one
// AXI4 INCR burst of 4-byte beats; read beats feed the pcore input FIFO, write beats
// drain the show-ahead output FIFO, and axi_done pulses once per request.
module axi_burst_responder #(
    parameter int unsigned RD_BEATS = 4,
    parameter int unsigned WR_BEATS = 256
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         rd_req,
    input  logic                         wr_req,
    input  logic [31:0]                  addr,
    output logic                         axi_done,
    output logic                         resp_err,
    output logic [31:0]                  rd_data,
    output logic                         rd_data_valid,
    input  logic [31:0]                  wr_data,
    input  logic                         wr_fifo_empty,
    output logic                         wr_data_pop,
    axi_burst_responder_if.master        axi
);
    localparam logic [8:0] RdLastIdx = 9'(RD_BEATS - 1);
    localparam logic [8:0] WrLastIdx = 9'(WR_BEATS - 1);
    localparam logic [7:0] RdLen     = 8'(RD_BEATS - 1);
    localparam logic [7:0] WrLen     = 8'(WR_BEATS - 1);

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StDone} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [8:0]  count_q;
    logic        resp_err_q;
    logic [31:0] rd_data_q;
    logic        rd_data_valid_q;

    logic load;
    logic r_beat;
    logic w_beat;
    logic w_valid;
    logic w_last;
    logic err_set;

    // Next-state decode and all AXI/FIFO strobes; outputs are gated by state so they
    // read as zero whenever the block is idle or held in reset.
    always_comb begin
        state_d        = state_q;
        load           = 1'b0;
        r_beat         = 1'b0;
        w_beat         = 1'b0;
        w_valid        = 1'b0;
        w_last         = 1'b0;
        axi_done       = 1'b0;
        wr_data_pop    = 1'b0;
        axi.m_arvalid  = 1'b0;
        axi.m_araddr   = 32'h0;
        axi.m_arlen    = 8'h0;
        axi.m_rready   = 1'b0;
        axi.m_awvalid  = 1'b0;
        axi.m_awaddr   = 32'h0;
        axi.m_awlen    = 8'h0;
        axi.m_wvalid   = 1'b0;
        axi.m_wdata    = 32'h0;
        axi.m_wstrb    = 4'h0;
        axi.m_wlast    = 1'b0;
        axi.m_bready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Read has priority when both requests are pending.
                if (rd_req) begin
                    state_d = StAr;
                    load    = 1'b1;
                end else if (wr_req) begin
                    state_d = StAw;
                    load    = 1'b1;
                end
            end
            StAr: begin
                axi.m_arvalid = 1'b1;
                axi.m_araddr  = addr_q;
                axi.m_arlen   = RdLen;
                if (axi.m_arready) state_d = StR;
            end
            StR: begin
                axi.m_rready = 1'b1;
                r_beat       = axi.m_rvalid;
                // rlast alone ends the burst, even if it comes early or late.
                if (axi.m_rvalid && axi.m_rlast) state_d = StDone;
            end
            StAw: begin
                axi.m_awvalid = 1'b1;
                axi.m_awaddr  = addr_q;
                axi.m_awlen   = WrLen;
                if (axi.m_awready) state_d = StW;
            end
            StW: begin
                // Show-ahead FIFO: head data is stable until popped, so a stalled beat
                // can only be withdrawn by the FIFO going empty, which it cannot do.
                w_valid      = !wr_fifo_empty;
                w_last       = (count_q == WrLastIdx);
                w_beat       = w_valid && axi.m_wready;
                axi.m_wvalid = w_valid;
                axi.m_wdata  = wr_data;
                axi.m_wstrb  = 4'hF;
                axi.m_wlast  = w_last;
                wr_data_pop  = w_beat;
                if (w_beat && w_last) state_d = StB;
            end
            StB: begin
                axi.m_bready = 1'b1;
                if (axi.m_bvalid) state_d = StDone;
            end
            StDone: begin
                axi_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Error sources: bad read response, rlast before the expected final beat, bad B response.
    always_comb begin
        err_set = 1'b0;
        if (r_beat && ((axi.m_rresp != 2'b00) || (axi.m_rlast && (count_q < RdLastIdx)))) begin
            err_set = 1'b1;
        end
        if ((state_q == StB) && axi.m_bvalid && (axi.m_bresp != 2'b00)) begin
            err_set = 1'b1;
        end
    end

    // State, address/beat bookkeeping, sticky error and the registered read push.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q         <= StIdle;
            addr_q          <= 32'h0;
            count_q         <= 9'h0;
            resp_err_q      <= 1'b0;
            rd_data_q       <= 32'h0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_data_valid_q <= r_beat;
            if (load) begin
                addr_q  <= addr;
                count_q <= 9'h0;
            end else if (r_beat || w_beat) begin
                count_q <= count_q + 9'h1;
            end
            if (r_beat) rd_data_q <= axi.m_rdata;
            if (err_set) resp_err_q <= 1'b1;
        end
    end

    assign resp_err      = resp_err_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
endmodule
